// File: rtl/deqam_run_ctrl.sv
// Run sequencer for the deQAM HLS core: issues ap_start per frame, counts completions
// and AXIS beats, and flags stream stalls with a per-channel block_info code.
module deqam_run_ctrl #(
  parameter int FRAME_LEN   = 64,
  parameter int CNT_W       = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [CNT_W-1:0] cfg_nframes,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             in_tvalid,
  input  logic             in_tready,
  input  logic             out_tvalid,
  input  logic             out_tready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_done,
  output logic [CNT_W-1:0] in_beats,
  output logic [CNT_W-1:0] out_beats,
  output logic             len_err,
  output logic             block,
  output logic [3:0]       block_info
);

  localparam int SW = $clog2(STALL_LIMIT);
  localparam logic [SW-1:0]    STALL_MAX = SW'(STALL_LIMIT - 1);
  localparam logic [SW-1:0]    STALL_ONE = SW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] FL        = CNT_W'(FRAME_LEN);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERROR} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] nframes_reg, nframes_next;
  logic [CNT_W-1:0] issued_reg, issued_next;
  logic [CNT_W-1:0] frames_reg, frames_next;
  logic [CNT_W-1:0] beats_reg [2];
  logic [CNT_W-1:0] beats_next [2];
  logic [CNT_W-1:0] beats_sat [2];
  logic             len_err_reg, len_err_next;
  logic [SW-1:0]    stall_reg, stall_next;
  logic [3:0]       info_reg, info_next;

  // Channel 0 is the core input stream, channel 1 the core output stream.
  logic [1:0] ch_valid, ch_ready, ch_xfer;
  logic [3:0] info_code;
  logic       idle_cyc;

  assign ch_valid = {out_tvalid, in_tvalid};
  assign ch_ready = {out_tready, in_tready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      assign ch_xfer[gi]   = ch_valid[gi] & ch_ready[gi];
      assign beats_sat[gi] = (ch_xfer[gi] && beats_reg[gi] != '1) ?
                             beats_reg[gi] + CNT_ONE : beats_reg[gi];
      // {!ready, !valid} yields 10 backpressure, 01 starved, 11 both idle.
      assign info_code[2*gi +: 2] = {~ch_ready[gi], ~ch_valid[gi]};
    end
  endgenerate

  assign idle_cyc = ~(|ch_xfer) & ~ap_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      nframes_reg <= '0;
      issued_reg  <= '0;
      frames_reg  <= '0;
      beats_reg   <= '{default: '0};
      len_err_reg <= 1'b0;
      stall_reg   <= '0;
      info_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      nframes_reg <= nframes_next;
      issued_reg  <= issued_next;
      frames_reg  <= frames_next;
      beats_reg   <= beats_next;
      len_err_reg <= len_err_next;
      stall_reg   <= stall_next;
      info_reg    <= info_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    nframes_next = nframes_reg;
    issued_next  = issued_reg;
    frames_next  = frames_reg;
    beats_next   = beats_reg;
    len_err_next = len_err_reg;
    stall_next   = stall_reg;
    info_next    = info_reg;
    if (cfg_abort) begin
      state_next = S_IDLE;
      info_next  = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cfg_start) begin
            nframes_next = cfg_nframes;
            issued_next  = '0;
            frames_next  = '0;
            beats_next   = '{default: '0};
            len_err_next = 1'b0;
            stall_next   = '0;
            state_next   = (cfg_nframes == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          beats_next = beats_sat;
          stall_next = idle_cyc ? stall_reg + STALL_ONE : '0;
          if (state_reg == S_ISSUE && ap_ready) begin
            issued_next = issued_reg + CNT_ONE;
            if (issued_next == nframes_reg) state_next = S_WAIT;
          end
          // Completion overrides the start handshake; the closing beat counts in this frame.
          if (ap_done) begin
            frames_next = frames_reg + CNT_ONE;
            if (beats_sat[0] != FL || beats_sat[1] != FL) len_err_next = 1'b1;
            beats_next = '{default: '0};
            if (frames_next == nframes_reg) state_next = S_DONE;
          end else if (idle_cyc && stall_reg == STALL_MAX) begin
            state_next = S_ERROR;
            info_next  = info_code;
          end
        end
        S_DONE:  state_next = S_IDLE;
        S_ERROR: state_next = S_ERROR;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // An abort masks ap_start at once so the core cannot accept a start we are abandoning.
  assign ap_start    = (state_reg == S_ISSUE) & ~cfg_abort;
  assign busy        = (state_reg == S_ISSUE) | (state_reg == S_WAIT);
  assign done        = (state_reg == S_DONE);
  assign block       = (state_reg == S_ERROR);
  assign block_info  = info_reg;
  assign frames_done = frames_reg;
  assign in_beats    = beats_reg[0];
  assign out_beats   = beats_reg[1];
  assign len_err     = len_err_reg;

endmodule

// File: doc/deqam_run_ctrl.md
Name: deqam_run_ctrl

Overview:
- Sequencing controller for the deQAM HLS core (ap_ctrl handshake plus one AXIS input and one AXIS output channel).
- Issues ap_start for a programmed number of frames and counts core completions and stream beats.
- A watchdog detects stream stalls and reports which channel blocked, using the same 2-bit-per-channel block_info encoding as the cosim deadlock monitors.
- Sits between the host/config register file and the deQAM core in the composable OFDM receive chain.

Parameters:
- FRAME_LEN, 64, expected AXIS beats per frame on each channel.
- CNT_W, 16, width of the frame and beat counters.
- STALL_LIMIT, 1024, consecutive no-transfer cycles before an error is declared; must be ≥ 2.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- cfg_start, input, 1, one-cycle pulse; starts a run; honoured only in IDLE.
- cfg_abort, input, 1, one-cycle pulse; returns to IDLE from any state.
- cfg_nframes, input, CNT_W, frames to run; latched on an accepted cfg_start.
- ap_start, output, 1, core start request.
- ap_ready, input, 1, core accepted a start.
- ap_done, input, 1, core finished one frame.
- in_tvalid, input, 1, tap of the core input AXIS valid.
- in_tready, input, 1, tap of the core input AXIS ready.
- out_tvalid, input, 1, tap of the core output AXIS valid.
- out_tready, input, 1, tap of the core output AXIS ready.
- busy, output, 1, high in ISSUE or WAIT.
- done, output, 1, one-cycle pulse when a run completes.
- frames_done, output, CNT_W, ap_done count for the current run.
- in_beats, output, CNT_W, input transfers in the current frame.
- out_beats, output, CNT_W, output transfers in the current frame.
- len_err, output, 1, sticky frame-length mismatch flag.
- block, output, 1, high in ERROR.
- block_info, output, 4, bits [1:0] input channel, bits [3:2] output channel.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE.
- Reset mid-run takes effect the next edge. No start pulse is left pending.
- States: IDLE, ISSUE, WAIT, DONE, ERROR.
- IDLE:
  - cfg_start with cfg_nframes ≠ 0: latch nframes, clear all counters and len_err, go to ISSUE.
  - cfg_start with cfg_nframes = 0: go to DONE without asserting ap_start.
- ISSUE:
  - ap_start = 1 combinationally from the state.
  - On ap_ready, issued increments. If the new issued value equals nframes, go to WAIT; otherwise stay in ISSUE with ap_start held high (back-to-back starts).
- WAIT: ap_start = 0; wait for the remaining completions.
- ap_done handling (ISSUE or WAIT):
  - frames_done increments.
  - If in_beats_next ≠ FRAME_LEN or out_beats_next ≠ FRAME_LEN, len_err is set. The _next values include any transfer in the same cycle.
  - in_beats and out_beats clear to 0; a transfer in that same cycle does not count toward the next frame.
  - When frames_done reaches nframes, go to DONE. This has priority over the ap_ready transition.
- DONE: done = 1 for exactly one cycle, then IDLE. Counters hold their values until the next accepted start.
- Beat counters count tvalid & tready on each channel, saturating at all-ones.
- Watchdog (ISSUE or WAIT only):
  - stall_cnt increments on every cycle with no transfer on either channel and no ap_done.
  - stall_cnt clears on any transfer or ap_done.
  - When stall_cnt reaches STALL_LIMIT-1 and the cycle is again idle, go to ERROR.
- block_info is registered in the cycle ERROR is entered, per channel:
  - 2'b10: valid & !ready (backpressure).
  - 2'b01: !valid & ready (starved).
  - 2'b11: !valid & !ready.
  - 2'b00: cannot occur on entry.
- ERROR: block = 1; block_info and all counters hold; ap_start = 0. Exit only via cfg_abort or reset.
- cfg_abort in any state: go to IDLE, ap_start = 0, block and block_info clear. Counters hold for debug.
- cfg_abort has priority over every other event in the same cycle.
- cfg_start is ignored outside IDLE.

Test Plan:
- nframes = 3, core answers ap_ready 2 cycles after each start, 64 beats per channel per frame, ap_done after each frame -> ap_start high for 3 accepted starts; done pulses once; frames_done = 3; len_err = 0; block = 0.
- nframes = 1, input frame carries 63 beats -> done pulses; len_err = 1; in_beats cleared after ap_done.
- In RUN, hold in_tvalid = 0, in_tready = 1, out_tvalid = 1, out_tready = 0 for STALL_LIMIT cycles -> block = 1; block_info = 4'b1001; ap_start = 0. Then cfg_abort -> block = 0, IDLE.
- cfg_nframes = 0 with cfg_start -> done pulse on the next cycle; ap_start never asserted.
- ap_done on the same edge as a transfer, and cfg_start during ISSUE -> the transfer counts in the closing frame; cfg_start has no effect.
- reset asserted while in WAIT -> next cycle all outputs 0 and the FSM in IDLE.
